// File: rtl/tetris_pkg.sv
// tetris_pkg: shared command codes, keycodes and key FSM states for the Tetris logic.
package tetris_pkg;
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5,
    CMD_PAUSE     = 3'd6
  } cmd_t;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_P     = 8'h13;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_REPEAT,
    ST_LATCHED
  } key_state_t;
  function automatic cmd_t decode_key(input logic [7:0] kc);
    return kc == KC_A     ? CMD_LEFT      :
           kc == KC_D     ? CMD_RIGHT     :
           kc == KC_W     ? CMD_ROTATE    :
           kc == KC_S     ? CMD_SOFT_DROP :
           kc == KC_SPACE ? CMD_HARD_DROP :
           kc == KC_P     ? CMD_PAUSE     : CMD_NONE;
  endfunction
  function automatic logic is_repeatable(input cmd_t c);
    return c == CMD_LEFT || c == CMD_RIGHT || c == CMD_SOFT_DROP;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer with a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);
  logic s1_q, s2_q, s3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign pulse_o = s2_q & ~s3_q;
endmodule

// File: rtl/key_cmd_gen.sv
// key_cmd_gen: frame-sampled keycode to game command with DAS/ARR and a one-entry output register.
module key_cmd_gen
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_FRAMES = 10,
  parameter int unsigned ARR_FRAMES = 3,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] overrun_cnt
);
  localparam logic [5:0] DAS_RELOAD = 6'(DAS_FRAMES - 1);
  localparam logic [5:0] ARR_RELOAD = 6'(ARR_FRAMES - 1);
  logic       tick;
  cmd_t       act;
  logic       rep;
  logic       emit;
  key_state_t state_q, state_d;
  cmd_t       held_q, held_d;
  logic [5:0] cnt_q, cnt_d;
  cmd_t       cmd_q;
  logic       valid_q;
  logic [7:0] ovr_q;
  sync_edge_det u_vs_sync (
    .clk     (Clk),
    .rst     (Reset),
    .async_i (vsync),
    .pulse_o (tick)
  );
  assign act = decode_key(keycode);
  assign rep = REPEAT_EN && is_repeatable(act);
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (tick) begin
      if (act == CMD_NONE) begin
        state_d = ST_IDLE;
        held_d  = CMD_NONE;
      end else if (act != held_q) begin
        emit    = 1'b1;
        held_d  = act;
        state_d = rep ? ST_FIRST : ST_LATCHED;
        cnt_d   = rep ? DAS_RELOAD : 6'd0;
      end else if (state_q == ST_FIRST || state_q == ST_REPEAT) begin
        emit    = cnt_q == 6'd0;
        cnt_d   = emit ? ARR_RELOAD : cnt_q - 6'd1;
        state_d = emit ? ST_REPEAT : state_q;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      held_q  <= CMD_NONE;
      cnt_q   <= 6'd0;
      cmd_q   <= CMD_NONE;
      valid_q <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      if (emit) begin
        cmd_q   <= act;
        valid_q <= 1'b1;
        if (valid_q && !cmd_ready && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      end else if (valid_q && cmd_ready) begin
        cmd_q   <= CMD_NONE;
        valid_q <= 1'b0;
      end
    end
  end
  assign cmd_valid   = valid_q;
  assign cmd         = cmd_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_key_cmd_gen.sv
// tb_key_cmd_gen: frame-level reference model of key_cmd_gen driven by directed and random key sequences.
module tb_key_cmd_gen;
  localparam int DAS = 10;
  localparam int ARR = 3;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vsync = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int errors = 0;
  int m_held = 0;
  int m_n = 0;
  logic m_valid = 1'b0;
  int m_cmd = 0;
  int m_ovr = 0;
  int hs = 0;
  int hs_cmd = 0;
  key_cmd_gen #(.DAS_FRAMES(DAS), .ARR_FRAMES(ARR), .REPEAT_EN(1'b1)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync       (vsync),
    .keycode     (keycode),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .overrun_cnt (overrun_cnt)
  );
  always #5 Clk = ~Clk;
  function automatic int key_action(input logic [7:0] k);
    case (k)
      8'h04: return 1;
      8'h07: return 2;
      8'h1A: return 3;
      8'h16: return 4;
      8'h2C: return 5;
      8'h13: return 6;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_tick(input logic rdy);
    int a;
    bit emit;
    a = key_action(keycode);
    emit = 0;
    if (a == 0) m_held = 0;
    else if (a != m_held) begin
      m_held = a;
      m_n = 0;
      emit = 1;
    end else begin
      m_n++;
      if ((a == 1 || a == 2 || a == 4) && m_n >= DAS && (m_n - DAS) % ARR == 0) emit = 1;
    end
    if (emit) begin
      if (m_valid && !rdy && m_ovr < 255) m_ovr++;
      m_cmd = a;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_cmd = 0;
      m_valid = 1'b0;
    end
  endtask
  task automatic cycle(input logic vs, input logic tick, input logic rdy);
    @(negedge Clk);
    vsync = vs;
    cmd_ready = rdy;
    if (cmd_valid && cmd_ready) begin
      hs++;
      hs_cmd = int'(cmd);
    end
    @(posedge Clk);
    if (tick) model_tick(rdy);
    else if (m_valid && rdy) begin
      m_cmd = 0;
      m_valid = 1'b0;
    end
    #1;
    chk("cmd_valid", {8'd0, cmd_valid}, {8'd0, m_valid});
    chk("cmd", {6'd0, cmd}, 9'(m_cmd));
    chk("overrun_cnt", {1'b0, overrun_cnt}, 9'(m_ovr));
  endtask
  task automatic frame(input logic [7:0] k, input int rmode);
    keycode = k;
    for (int c = 0; c < 10; c++)
      cycle(c < 4, c == 2, rmode == 2 ? 1'($urandom_range(0, 1)) : 1'(rmode));
  endtask
  task automatic frames(input logic [7:0] k, input int n, input int rmode);
    for (int i = 0; i < n; i++) frame(k, rmode);
  endtask
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    vsync = 1'b0;
    @(posedge Clk);
    #1;
    m_held = 0; m_n = 0; m_valid = 1'b0; m_cmd = 0; m_ovr = 0;
    chk("reset_valid", {8'd0, cmd_valid}, 9'd0);
    chk("reset_cmd", {6'd0, cmd}, 9'd0);
    chk("reset_ovr", {1'b0, overrun_cnt}, 9'd0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask
  initial begin
    logic [7:0] keys [9];
    keys = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h13, 8'h29, 8'h00};
    do_reset();
    // tap
    hs = 0;
    frame(8'h04, 1);
    frames(8'h00, 3, 1);
    chk("tap_count", 9'(hs), 9'd1);
    chk("tap_cmd", 9'(hs_cmd), 9'd1);
    // hold repeat
    hs = 0;
    frames(8'h07, 20, 1);
    frame(8'h00, 1);
    chk("repeat_count", 9'(hs), 9'd5);
    // one-shot keys
    foreach (keys[i]) begin
      if (i >= 3 && i != 4 && i <= 6) begin
        hs = 0;
        frames(keys[i], 20, 1);
        frame(8'h00, 1);
        frames(keys[i], 5, 1);
        frame(8'h00, 1);
        chk("oneshot_count", 9'(hs), 9'd2);
        chk("oneshot_cmd", 9'(hs_cmd), 9'(i));
      end
    end
    // backpressure
    frames(8'h16, 11, 0);
    chk("bp_ovr", {1'b0, overrun_cnt}, 9'd1);
    chk("bp_cmd", {6'd0, cmd}, 9'd4);
    frame(8'h00, 1);
    chk("bp_drain", {8'd0, cmd_valid}, 9'd0);
    // reset mid-repeat
    frames(8'h07, 15, 2);
    do_reset();
    hs = 0;
    frame(8'h07, 1);
    frame(8'h07, 1);
    chk("post_reset_emit", 9'(hs), 9'd1);
    chk("post_reset_cmd", 9'(hs_cmd), 9'd2);
    // unmapped key and direct switch
    frame(8'h00, 1);
    hs = 0;
    frames(8'h29, 5, 1);
    chk("unmapped", 9'(hs), 9'd0);
    frames(8'h04, 12, 1);
    hs = 0;
    frames(8'h07, 11, 1);
    frame(8'h00, 1);
    chk("switch_count", 9'(hs), 9'd2);
    chk("switch_cmd", 9'(hs_cmd), 9'd2);
    // random segments
    for (int s = 0; s < 40; s++) begin
      int ki;
      logic [7:0] k;
      ki = $urandom_range(0, 9);
      k = ki == 9 ? 8'($urandom) : keys[ki];
      frames(k, $urandom_range(1, 25), $urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    // overrun saturation
    frames(8'h04, 800, 0);
    chk("ovr_saturate", {1'b0, overrun_cnt}, 9'd255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
